mesh_packet_injector: RTL and testbench

Tile-side packet source that drives one router's local (P) input port of the 2-D mesh using the ready&valid handshake. On command it emits a burst of packets formatted as {payload, y_cord, x_cord}. Destinations are either fixed or a raster sweep of every other tile. It is the transmitter counterpart of the router's input link. It supplies the stimulus whose delivery the network checkers track.

---
 rtl/mesh_packet_injector.sv | 165 ++++++++++++++++
 tb/tb_mesh_packet_injector.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mesh_packet_injector.sv
// Tile-side packet source for a router's local input port. On a start
// command it emits a burst of {payload, y_cord, x_cord} packets over a
// ready&valid link, either to one fixed tile or sweeping every other tile
// in raster order, with an optional idle gap after each handshake.
module mesh_packet_injector #(
    parameter  int data_width_p   = 4,
    parameter  int x_cord_width_p = 2,
    parameter  int y_cord_width_p = 2,
    parameter  int len_width_p    = 8,
    parameter  int gap_width_p    = 4,
    localparam int width_lp       = data_width_p + y_cord_width_p + x_cord_width_p
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start_i,
    input  logic                      mode_i,
    input  logic [len_width_p-1:0]    burst_len_i,
    input  logic [gap_width_p-1:0]    gap_i,
    input  logic [x_cord_width_p-1:0] dest_x_i,
    input  logic [y_cord_width_p-1:0] dest_y_i,
    input  logic [x_cord_width_p-1:0] my_x_i,
    input  logic [y_cord_width_p-1:0] my_y_i,
    output logic                      v_o,
    output logic [width_lp-1:0]       data_o,
    input  logic                      ready_and_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [len_width_p-1:0]    sent_cnt_o
);

    // {y, x} treated as one counter: incrementing it walks X first, then Y,
    // and (xmax, ymax) rolls over to (0, 0) for free.
    localparam int pos_w_lp = x_cord_width_p + y_cord_width_p;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e                    state_q, state_d;
    logic [width_lp-1:0]       data_q, data_d;
    logic [data_width_p-1:0]   seq_q, seq_d;
    logic [pos_w_lp-1:0]       pos_q, pos_d;
    logic                      mode_q, mode_d;
    logic [len_width_p-1:0]    len_q, len_d;
    logic [gap_width_p-1:0]    gap_q, gap_d;
    logic [gap_width_p-1:0]    gap_cnt_q, gap_cnt_d;
    logic [len_width_p-1:0]    sent_cnt_q, sent_cnt_d;
    logic                      v_q, busy_q, done_q;

    logic                      handshake;
    logic [pos_w_lp-1:0]       my_pos;
    logic [pos_w_lp-1:0]       sweep_first;
    logic [pos_w_lp-1:0]       sweep_step;
    logic [pos_w_lp-1:0]       sweep_next;
    logic [pos_w_lp-1:0]       start_pos;
    logic [pos_w_lp-1:0]       next_pos;
    logic [data_width_p-1:0]   seq_inc;

    assign handshake   = v_q & ready_and_i;
    assign my_pos      = {my_y_i, my_x_i};
    // Self is skipped both at burst start and when advancing; one extra
    // step is always enough because only one position equals self.
    assign sweep_first = (my_pos == '0) ? pos_w_lp'(1) : '0;
    assign sweep_step  = pos_q + pos_w_lp'(1);
    assign sweep_next  = (sweep_step == my_pos) ? sweep_step + pos_w_lp'(1) : sweep_step;
    assign start_pos   = mode_i ? sweep_first : {dest_y_i, dest_x_i};
    // In fixed mode pos_q simply keeps holding the sampled destination.
    assign next_pos    = mode_q ? sweep_next : pos_q;
    assign seq_inc     = seq_q + data_width_p'(1);

    // Next-state and next-packet logic for the burst FSM.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned, which would infer a latch.
        state_d    = state_q;
        data_d     = data_q;
        seq_d      = seq_q;
        pos_d      = pos_q;
        mode_d     = mode_q;
        len_d      = len_q;
        gap_d      = gap_q;
        gap_cnt_d  = gap_cnt_q;
        sent_cnt_d = sent_cnt_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    mode_d     = mode_i;
                    len_d      = burst_len_i;
                    gap_d      = gap_i;
                    seq_d      = '0;
                    sent_cnt_d = '0;
                    pos_d      = start_pos;
                    data_d     = {{data_width_p{1'b0}}, start_pos};
                    state_d    = (burst_len_i == '0) ? DONE : SEND;
                end
            end
            SEND: begin
                if (handshake) begin
                    sent_cnt_d = sent_cnt_q + len_width_p'(1);
                    seq_d      = seq_inc;
                    pos_d      = next_pos;
                    data_d     = {seq_inc, next_pos};
                    if (sent_cnt_q == len_q - len_width_p'(1)) begin
                        state_d = DONE;
                    end else if (gap_q != '0) begin
                        gap_cnt_d = gap_q;
                        state_d   = GAP;
                    end
                end
            end
            GAP: begin
                // Count of 1 means this is the last idle cycle.
                if (gap_cnt_q == gap_width_p'(1)) begin
                    gap_cnt_d = '0;
                    state_d   = SEND;
                end else begin
                    gap_cnt_d = gap_cnt_q - gap_width_p'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; status outputs are decoded from the next state so they are registered too.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
            state_q    <= IDLE;
            data_q     <= '0;
            seq_q      <= '0;
            pos_q      <= '0;
            mode_q     <= 1'b0;
            len_q      <= '0;
            gap_q      <= '0;
            gap_cnt_q  <= '0;
            sent_cnt_q <= '0;
            v_q        <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            seq_q      <= seq_d;
            pos_q      <= pos_d;
            mode_q     <= mode_d;
            len_q      <= len_d;
            gap_q      <= gap_d;
            gap_cnt_q  <= gap_cnt_d;
            sent_cnt_q <= sent_cnt_d;
            v_q        <= (state_d == SEND);
            busy_q     <= (state_d != IDLE);
            done_q     <= (state_d == DONE);
        end
    end

    assign v_o        = v_q;
    assign data_o     = data_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign sent_cnt_o = sent_cnt_q;

endmodule

// File: tb/tb_mesh_packet_injector.sv
// Scoreboard bench for mesh_packet_injector: stimulus pushes expected
// packets, a negedge monitor pops and compares on every handshake and
// also checks that a stalled packet stays valid and stable.
module tb_mesh_packet_injector;

    logic       clk;
    logic       reset_n;
    logic       start_i;
    logic       mode_i;
    logic [7:0] burst_len_i;
    logic [3:0] gap_i;
    logic [1:0] dest_x_i;
    logic [1:0] dest_y_i;
    logic [1:0] my_x_i;
    logic [1:0] my_y_i;
    logic       v_o;
    logic [7:0] data_o;
    logic       ready_and_i;
    logic       busy_o;
    logic       done_o;
    logic [7:0] sent_cnt_o;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] sb[$];
    logic       stalled;
    logic [7:0] held;

    mesh_packet_injector dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start_i     (start_i),
        .mode_i      (mode_i),
        .burst_len_i (burst_len_i),
        .gap_i       (gap_i),
        .dest_x_i    (dest_x_i),
        .dest_y_i    (dest_y_i),
        .my_x_i      (my_x_i),
        .my_y_i      (my_y_i),
        .v_o         (v_o),
        .data_o      (data_o),
        .ready_and_i (ready_and_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .sent_cnt_o  (sent_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command for one cycle, then scramble the command inputs.
    task automatic start_burst(input logic m, input logic [7:0] len, input logic [3:0] gap,
                               input logic [1:0] dx, input logic [1:0] dy);
        mode_i      = m;
        burst_len_i = len;
        gap_i       = gap;
        dest_x_i    = dx;
        dest_y_i    = dy;
        start_i     = 1'b1;
        tick();
        start_i     = 1'b0;
        mode_i      = ~m;
        burst_len_i = 8'hA5;
        gap_i       = 4'hF;
        dest_x_i    = ~dx;
        dest_y_i    = ~dy;
    endtask

    task automatic push_fixed(input int len, input logic [1:0] dx, input logic [1:0] dy);
        for (int i = 0; i < len; i++) begin
            sb.push_back({i[3:0], dy, dx});
        end
    endtask

    task automatic wait_done(input string name, input int budget);
        int cycles = 0;
        while (!done_o && cycles < budget) begin
            tick();
            cycles++;
        end
        check(name, done_o, 1);
        tick();
        check({name, "_sb_empty"}, sb.size(), 0);
    endtask

    // Monitor: scoreboard pop on handshake, stability check while stalled.
    always @(negedge clk) begin
        if (!reset_n) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("hold_valid", v_o, 1);
                check("hold_data", data_o, held);
            end
            if (v_o && ready_and_i) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL pkt_unexpected: got 0x%0h expected no packet at %0t", data_o, $time);
                end else begin
                    check("pkt_data", data_o, sb.pop_front());
                end
            end
            stalled = v_o && !ready_and_i;
            held    = data_o;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n     = 1'b0;
        start_i     = 1'b0;
        mode_i      = 1'b0;
        burst_len_i = 8'd0;
        gap_i       = 4'd0;
        dest_x_i    = 2'd0;
        dest_y_i    = 2'd0;
        my_x_i      = 2'd1;
        my_y_i      = 2'd0;
        ready_and_i = 1'b1;
        repeat (3) tick();
        check("rst_v", v_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_sent", sent_cnt_o, 0);
        check("rst_data", data_o, 0);
        @(posedge clk);
        #2 reset_n = 1'b1;
        tick();

        // Fixed burst, len 3, dest (2,1): 0x06, 0x16, 0x26 back to back.
        ready_and_i = 1'b1;
        sb.push_back(8'h06); sb.push_back(8'h16); sb.push_back(8'h26);
        start_burst(1'b0, 8'd3, 4'd0, 2'd2, 2'd1);
        check("fix_v_first", v_o, 1);
        check("fix_busy", busy_o, 1);
        check("fix_sent0", sent_cnt_o, 0);
        tick(); check("fix_v2", v_o, 1);
        tick(); check("fix_v3", v_o, 1);
        tick();
        check("fix_done", done_o, 1);
        check("fix_v_end", v_o, 0);
        check("fix_sent3", sent_cnt_o, 3);
        tick();
        check("fix_done_pulse", done_o, 0);
        check("fix_idle", busy_o, 0);
        check("fix_sent_hold", sent_cnt_o, 3);
        check("fix_sb_empty", sb.size(), 0);

        // Backpressure: ready low 5 cycles after v_o rises.
        ready_and_i = 1'b0;
        sb.push_back(8'h06); sb.push_back(8'h16);
        start_burst(1'b0, 8'd2, 4'd0, 2'd2, 2'd1);
        for (int i = 0; i < 5; i++) begin
            check("bp_v", v_o, 1);
            check("bp_data", data_o, 8'h06);
            tick();
        end
        ready_and_i = 1'b1;
        tick();
        check("bp_second_v", v_o, 1);
        check("bp_second_data", data_o, 8'h16);
        tick();
        check("bp_done", done_o, 1);
        check("bp_sent", sent_cnt_o, 2);
        tick();

        // Sweep, my=(1,0): (0,0),(2,0),(3,0),(0,1) with payloads 0..3.
        my_x_i = 2'd1; my_y_i = 2'd0;
        sb.push_back(8'h00); sb.push_back(8'h12); sb.push_back(8'h23); sb.push_back(8'h34);
        start_burst(1'b1, 8'd4, 4'd0, 2'd3, 2'd3);
        wait_done("sweep_my10", 20);
        check("sweep_my10_sent", sent_cnt_o, 4);

        // Sweep, my=(0,0): start position itself is skipped -> (1,0),(2,0),(3,0).
        my_x_i = 2'd0; my_y_i = 2'd0;
        sb.push_back(8'h01); sb.push_back(8'h12); sb.push_back(8'h23);
        start_burst(1'b1, 8'd3, 4'd0, 2'd0, 2'd0);
        wait_done("sweep_my00", 20);

        // Sweep, my=(3,3), len 16: 15 tiles with payload == raster index, then wrap to (0,0) with payload 15.
        my_x_i = 2'd3; my_y_i = 2'd3;
        for (int i = 0; i < 15; i++) sb.push_back({i[3:0], i[3:0]});
        sb.push_back(8'hF0);
        start_burst(1'b1, 8'd16, 4'd0, 2'd0, 2'd0);
        wait_done("sweep_wrap", 40);
        check("sweep_wrap_sent", sent_cnt_o, 16);

        // Gap 3, len 2, dest (1,2): v 1,0,0,0,1 then done.
        sb.push_back(8'h09); sb.push_back(8'h19);
        start_burst(1'b0, 8'd2, 4'd3, 2'd1, 2'd2);
        check("gap_v0", v_o, 1);
        tick(); check("gap_v1", v_o, 0);
        tick(); check("gap_v2", v_o, 0);
        tick(); check("gap_v3", v_o, 0);
        check("gap_busy", busy_o, 1);
        tick(); check("gap_v4", v_o, 1);
        tick(); check("gap_done", done_o, 1);
        check("gap_v5", v_o, 0);
        tick();

        // Zero-length burst: done next cycle, no valid.
        start_burst(1'b0, 8'd0, 4'd0, 2'd2, 2'd1);
        check("len0_done", done_o, 1);
        check("len0_v", v_o, 0);
        check("len0_sent", sent_cnt_o, 0);
        tick();
        check("len0_done_pulse", done_o, 0);
        check("len0_idle", busy_o, 0);

        // Start while busy is ignored: only the original 3 packets.
        push_fixed(3, 2'd3, 2'd0);
        start_burst(1'b0, 8'd3, 4'd2, 2'd3, 2'd0);
        start_i = 1'b1; burst_len_i = 8'd5; mode_i = 1'b1;
        repeat (3) tick();
        start_i = 1'b0;
        wait_done("busy_start", 30);
        check("busy_start_sent", sent_cnt_o, 3);

        // len 20 to dest (3,3): payload wraps 15 -> 0.
        push_fixed(20, 2'd3, 2'd3);
        start_burst(1'b0, 8'd20, 4'd0, 2'd3, 2'd3);
        wait_done("len20", 40);
        check("len20_sent", sent_cnt_o, 20);

        // Reset mid-burst while a packet is stalled.
        ready_and_i = 1'b0;
        push_fixed(4, 2'd0, 2'd3);
        start_burst(1'b0, 8'd4, 4'd0, 2'd0, 2'd3);
        ready_and_i = 1'b1;
        tick();
        ready_and_i = 1'b0;
        tick();
        check("mid_sent1", sent_cnt_o, 1);
        check("mid_v", v_o, 1);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_v", v_o, 0);
        check("mid_rst_busy", busy_o, 0);
        check("mid_rst_sent", sent_cnt_o, 0);
        check("mid_rst_data", data_o, 0);
        sb.delete();
        @(posedge clk);
        #2 reset_n = 1'b1;
        tick();
        ready_and_i = 1'b1;
        sb.push_back(8'h06); sb.push_back(8'h16);
        start_burst(1'b0, 8'd2, 4'd0, 2'd2, 2'd1);
        wait_done("post_rst", 20);
        check("post_rst_sent", sent_cnt_o, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
